// File: rtl/lfsr_dbi_checker_if.sv
// Received-word bus between the lane deserialiser and the PRBS16/DBI checker.
// The deserialiser drives it; the checker only observes it.
interface lfsr_dbi_checker_if #(
    parameter int N = 16
) ();
    logic         rx_valid;
    logic [1:N]   rx_data;

    modport master (output rx_valid, output rx_data);
    modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/lfsr_dbi_checker.sv
// Receive-side checker for the DBI-encoded PRBS16 link-test pattern: predicts the
// next word, tracks acquisition/lock, and keeps saturating error statistics.
module lfsr_dbi_checker #(
    parameter int N          = 16,
    parameter int DBI_THRESH = 7,
    parameter int LOCK_CNT   = 8,
    parameter int LOSS_CNT   = 4,
    parameter int CW         = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clr,
    lfsr_dbi_checker_if.slave     rx,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CW-1:0]         word_cnt,
    output logic [CW-1:0]         err_word_cnt,
    output logic [CW-1:0]         err_bit_cnt,
    output logic [1:0]            state
);

    localparam int             PW     = $clog2(N + 1);
    localparam logic [PW-1:0]  DBI_T  = PW'(DBI_THRESH);
    localparam logic [7:0]     LOCK_T = 8'(LOCK_CNT);
    localparam logic [7:0]     LOSS_T = 8'(LOSS_CNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        ACQ    = 2'd2,
        LOCKED = 2'd3
    } state_e;

    state_e        fsm_q;
    logic [1:N]    prev_q;
    logic [7:0]    match_run_q;
    logic [7:0]    err_run_q;

    logic [1:N]    cand;
    logic [1:N]    expected;
    logic [PW-1:0] toggles;
    logic [PW-1:0] diff_bits;
    logic          is_match;
    logic          is_stuck;
    logic          count_word;
    logic          count_err;
    logic [CW:0]   bit_sum;
    logic [CW-1:0] bit_cnt_next;

    function automatic logic [PW-1:0] popcount(input logic [1:N] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 1; i <= N; i++) n = n + PW'(v[i]);
        return n;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        cand         = {prev_q[N] ^ prev_q[N-1] ^ prev_q[N-3] ^ prev_q[4], prev_q[1:N-1]};
        toggles      = popcount(cand ^ prev_q);
        expected     = (toggles > DBI_T) ? ~cand : cand;
        diff_bits    = popcount(rx.rx_data ^ expected);
        is_match     = (rx.rx_data == expected);
        is_stuck     = (rx.rx_data == '0) || (rx.rx_data == '1);
        count_word   = en && rx.rx_valid && (fsm_q == LOCKED);
        count_err    = count_word && !is_match;
        bit_sum      = {1'b0, err_bit_cnt} + (CW+1)'(diff_bits);
        // Overflow into the extra bit means the sum no longer fits: clamp instead of wrapping.
        bit_cnt_next = bit_sum[CW] ? '1 : bit_sum[CW-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q        <= IDLE;
            prev_q       <= '0;
            match_run_q  <= '0;
            err_run_q    <= '0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            word_cnt     <= '0;
            err_word_cnt <= '0;
            err_bit_cnt  <= '0;
        end else begin
            err_pulse <= 1'b0;

            if (!en) begin
                fsm_q  <= IDLE;
                locked <= 1'b0;
            end else begin
                case (fsm_q)
                    IDLE: fsm_q <= SEED;
                    SEED: if (rx.rx_valid) begin
                        prev_q      <= rx.rx_data;
                        match_run_q <= '0;
                        fsm_q       <= ACQ;
                    end
                    ACQ: if (rx.rx_valid) begin
                        prev_q <= rx.rx_data;
                        if (is_match && !is_stuck) begin
                            match_run_q <= match_run_q + 8'd1;
                            if (match_run_q + 8'd1 == LOCK_T) begin
                                fsm_q     <= LOCKED;
                                locked    <= 1'b1;
                                err_run_q <= '0;
                            end
                        end else begin
                            match_run_q <= '0;
                        end
                    end
                    LOCKED: if (rx.rx_valid) begin
                        // Flywheel on the prediction so a single corrupted word is counted once.
                        prev_q <= expected;
                        if (!is_match) begin
                            err_pulse <= 1'b1;
                            err_run_q <= err_run_q + 8'd1;
                            if (err_run_q + 8'd1 == LOSS_T) begin
                                fsm_q       <= ACQ;
                                locked      <= 1'b0;
                                match_run_q <= '0;
                                err_run_q   <= '0;
                                prev_q      <= rx.rx_data;
                            end
                        end else begin
                            err_run_q <= '0;
                        end
                    end
                    default: fsm_q <= IDLE;
                endcase
            end

            if (clr) begin
                word_cnt     <= '0;
                err_word_cnt <= '0;
                err_bit_cnt  <= '0;
            end else begin
                if (count_word) word_cnt <= sat_inc(word_cnt);
                if (count_err) begin
                    err_word_cnt <= sat_inc(err_word_cnt);
                    err_bit_cnt  <= bit_cnt_next;
                end
            end
        end
    end

    assign state = fsm_q;

endmodule
